imem_responder: RTL and testbench

Responder end of the instruction-fetch memory interface: the memory-side block that answers mem_in_type requests from the fetch buffer's imem port with mem_out_type responses.
- Backed by a local word-addressed storage array with programmable access latency.
- Cancels in-flight requests when the initiator redirects, reports access errors, and accepts byte-strobed writes for program loading.
- Sits between the fetch buffer's imem port and the instruction storage.

---
 rtl/imem_responder_pkg.sv | 60 ++++++
 rtl/imem_ram.sv | 25 ++
 rtl/imem_responder.sv | 124 ++++++++++++
 tb/tb_imem_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and configuration for the instruction-memory responder:
// request/response structs, storage-port structs and the control register.
package imem_responder_pkg;

   localparam int          imem_depth        = 10;
   localparam int          imem_latency_dflt = 2;
   localparam logic [31:0] imem_base_dflt    = 32'h0;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_fence;
      logic        mem_spec;
      logic        mem_instr;
      logic [1:0]  mem_mode;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic [31:0] mem_rdata;
      logic        mem_error;
      logic        mem_ready;
   } mem_out_type;

   typedef struct packed {
      logic [3:0]            wen;
      logic [imem_depth-1:0] waddr;
      logic [imem_depth-1:0] raddr;
      logic [31:0]           wdata;
   } imem_ram_in_type;

   typedef struct packed {
      logic [31:0] rdata;
   } imem_ram_out_type;

   typedef enum logic {IDLE, BUSY} imem_state_type;

   typedef struct packed {
      imem_state_type state;
      logic [3:0]     count;
      logic [31:0]    addr;
      logic [31:0]    wdata;
      logic [3:0]     wstrb;
      mem_out_type    resp;
   } imem_reg_type;

   // Offset wraps at 32 bits, so addresses below the base land far out of range.
   function automatic logic imem_addr_error(logic [31:0] addr, logic [31:0] base);
      logic [31:0] offset;
      offset = addr - base;
      return (addr[1:0] != 2'b00) || ((offset >> (imem_depth + 2)) != 32'h0);
   endfunction

   function automatic logic [imem_depth-1:0] imem_word_index(logic [31:0] addr,
                                                             logic [31:0] base);
      return imem_depth'((addr - base) >> 2);
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Word-addressed instruction storage: combinational read port and a
// byte-enabled synchronous write port.
module imem_ram
   import imem_responder_pkg::*;
(
   input  logic             clk,
   input  imem_ram_in_type  ram_in,
   output imem_ram_out_type ram_out
);

   logic [31:0] mem_q [2**imem_depth];

   // NOTE: storage is deliberately left out of reset; clearing every word
   // would need a multi-cycle sequencer and nothing depends on its contents.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_in.wen[b]) begin
            mem_q[ram_in.waddr][8*b +: 8] <= ram_in.wdata[8*b +: 8];
         end
      end
   end

   assign ram_out.rdata = mem_q[ram_in.raddr];

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for the fetch buffer's imem port: accepts a request,
// waits imem_latency cycles, then answers with a one-cycle registered response.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int          imem_latency = imem_latency_dflt,
   parameter logic [31:0] imem_base    = imem_base_dflt
) (
   input  logic        clk,
   input  logic        rst,
   input  mem_in_type  imem_in,
   output mem_out_type imem_out
);

   imem_reg_type     r_q, r_d;
   imem_ram_in_type  ram_in;
   imem_ram_out_type ram_out;

   logic        accept;
   logic        abort;
   logic        do_access;
   logic        acc_error;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [3:0]  acc_wstrb;

   logic unused_in;
   assign unused_in = &{1'b0, imem_in.mem_fence, imem_in.mem_instr, imem_in.mem_mode};

   imem_ram u_ram (
      .clk     (clk),
      .ram_in  (ram_in),
      .ram_out (ram_out)
   );

   // Access decision and storage port; kept apart from the register update
   // so the combinational read path does not loop back into its own address.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path through the branches can leave a value held (which would be a latch).
      accept    = 1'b0;
      abort     = 1'b0;
      do_access = 1'b0;
      acc_addr  = r_q.addr;
      acc_wdata = r_q.wdata;
      acc_wstrb = r_q.wstrb;

      case (r_q.state)
         IDLE: accept = imem_in.mem_valid;
         BUSY: begin
            abort = !imem_in.mem_valid || imem_in.mem_spec ||
                    (imem_in.mem_addr != r_q.addr);
            if (abort) begin
               accept = imem_in.mem_valid;
            end else if (r_q.count == 4'd0) begin
               do_access = 1'b1;
            end
         end
         default: ;
      endcase

      if (accept && (imem_latency == 1)) begin
         do_access = 1'b1;
         acc_addr  = imem_in.mem_addr;
         acc_wdata = imem_in.mem_wdata;
         acc_wstrb = imem_in.mem_wstrb;
      end

      acc_error    = imem_addr_error(acc_addr, imem_base);
      ram_in       = '0;
      ram_in.raddr = imem_word_index(acc_addr, imem_base);
      ram_in.waddr = ram_in.raddr;
      ram_in.wdata = acc_wdata;
      if (do_access && !acc_error && rst) begin
         ram_in.wen = acc_wstrb;
      end
   end

   always_comb begin
      r_d      = r_q;
      r_d.resp = '0;

      if (r_q.state == BUSY) begin
         if (abort || (r_q.count == 4'd0)) begin
            r_d.state = IDLE;
         end else begin
            r_d.count = r_q.count - 4'd1;
         end
      end

      if (accept) begin
         r_d.addr  = imem_in.mem_addr;
         r_d.wdata = imem_in.mem_wdata;
         r_d.wstrb = imem_in.mem_wstrb;
         if (imem_latency == 1) begin
            r_d.state = IDLE;
         end else begin
            r_d.state = BUSY;
            r_d.count = 4'(imem_latency - 2);
         end
      end

      if (do_access) begin
         r_d.resp.mem_ready = 1'b1;
         r_d.resp.mem_error = acc_error;
         if (!acc_error && (acc_wstrb == 4'h0)) begin
            r_d.resp.mem_rdata = ram_out.rdata;
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= '0;
      end else begin
         r_q <= r_d;
      end
   end

   assign imem_out = r_q.resp;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder at default parameters (latency 2, 1K words,
// base 0): a vector table of back-to-back requests plus abort/reset sequences.
module tb_imem_responder;
   import imem_responder_pkg::*;

   logic        clk;
   logic        rst;
   mem_in_type  in_s;
   mem_out_type out_s;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic        exp_error;
   } vec_t;

   vec_t vecs[$];

   imem_responder dut (
      .clk      (clk),
      .rst      (rst),
      .imem_in  (in_s),
      .imem_out (out_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Holds the request until mem_ready; lat is the cycle it appeared in, 0 on timeout.
   task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         output int lat, output mem_out_type rsp);
      in_s.mem_valid = 1'b1;
      in_s.mem_spec  = 1'b0;
      in_s.mem_addr  = a;
      in_s.mem_wdata = wd;
      in_s.mem_wstrb = ws;
      lat = 0;
      rsp = '0;
      for (int n = 1; n <= 20; n++) begin
         next_cycle();
         if (out_s.mem_ready) begin
            lat = n;
            rsp = out_s;
            break;
         end
      end
   endtask

   task automatic quiet(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         next_cycle();
         check(name, 32'(out_s.mem_ready), 32'd0);
      end
   endtask

   initial begin
      int          lat;
      mem_out_type rsp;

      // Preload, stream reads, errors, strobed write, top-of-range word.
      vecs.push_back('{32'h0000_0014, 32'h0000_0013, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{32'h0000_0000, 32'hA0A0_A0A0, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{32'h0000_0004, 32'hB1B1_B1B1, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{32'h0000_0008, 32'h1122_3344, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{32'h0000_0040, 32'hC0FF_EE16, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{32'h0000_0020, 32'hDEAD_0020, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{32'h0000_0014, 32'h0,         4'h0, 32'h0000_0013, 1'b0});
      vecs.push_back('{32'h0000_0000, 32'h0,         4'h0, 32'hA0A0_A0A0, 1'b0});
      vecs.push_back('{32'h0000_0004, 32'h0,         4'h0, 32'hB1B1_B1B1, 1'b0});
      vecs.push_back('{32'h0000_0008, 32'h0,         4'h0, 32'h1122_3344, 1'b0});
      vecs.push_back('{32'h0000_1000, 32'h0,         4'h0, 32'h0,         1'b1});
      vecs.push_back('{32'h0000_0002, 32'h0,         4'h0, 32'h0,         1'b1});
      vecs.push_back('{32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0,         1'b1});
      vecs.push_back('{32'h0000_0000, 32'h0,         4'h0, 32'hA0A0_A0A0, 1'b0});
      vecs.push_back('{32'h0000_0008, 32'hAABB_CCDD, 4'h3, 32'h0,         1'b0});
      vecs.push_back('{32'h0000_0008, 32'h0,         4'h0, 32'h1122_CCDD, 1'b0});
      vecs.push_back('{32'h0000_0FFC, 32'h5A5A_5A5A, 4'hF, 32'h0,         1'b0});
      vecs.push_back('{32'h0000_0FFC, 32'h0,         4'h0, 32'h5A5A_5A5A, 1'b0});
      vecs.push_back('{32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1});

      rst  = 1'b0;
      in_s = '0;
      repeat (3) next_cycle();
      check("reset ready", 32'(out_s.mem_ready), 32'd0);
      check("reset error", 32'(out_s.mem_error), 32'd0);
      check("reset rdata", out_s.mem_rdata, 32'h0);
      rst = 1'b1;
      next_cycle();

      // Back-to-back: each next request is presented in the ready cycle.
      foreach (vecs[i]) begin
         do_req(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat, rsp);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
         check($sformatf("vec%0d rdata", i), rsp.mem_rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d error", i), 32'(rsp.mem_error), 32'(vecs[i].exp_error));
      end
      in_s.mem_valid = 1'b0;
      quiet("idle after stream", 3);

      // Redirect: 0x20 accepted, address moves to 0x40 one cycle later.
      in_s.mem_valid = 1'b1;
      in_s.mem_addr  = 32'h20;
      in_s.mem_wstrb = 4'h0;
      next_cycle();
      check("redirect c1 ready", 32'(out_s.mem_ready), 32'd0);
      in_s.mem_addr = 32'h40;
      next_cycle();
      check("redirect c2 ready", 32'(out_s.mem_ready), 32'd0);
      next_cycle();
      check("redirect c3 ready", 32'(out_s.mem_ready), 32'd1);
      check("redirect c3 rdata", out_s.mem_rdata, 32'hC0FF_EE16);
      in_s.mem_valid = 1'b0;
      quiet("idle after redirect", 2);

      // Initiator withdraws valid while BUSY: no response at all.
      in_s.mem_valid = 1'b1;
      in_s.mem_addr  = 32'h4;
      next_cycle();
      in_s.mem_valid = 1'b0;
      quiet("withdrawn request", 4);

      // One-cycle speculative pulse aborts and restarts the same address.
      in_s.mem_valid = 1'b1;
      in_s.mem_addr  = 32'h4;
      next_cycle();
      check("spec c1 ready", 32'(out_s.mem_ready), 32'd0);
      in_s.mem_spec = 1'b1;
      next_cycle();
      check("spec c2 ready", 32'(out_s.mem_ready), 32'd0);
      in_s.mem_spec = 1'b0;
      next_cycle();
      check("spec c3 ready", 32'(out_s.mem_ready), 32'd1);
      check("spec c3 rdata", out_s.mem_rdata, 32'hB1B1_B1B1);
      in_s.mem_valid = 1'b0;
      quiet("idle after spec", 2);

      // Reset in cycle 1 of a read drops it; the next read completes normally.
      in_s.mem_valid = 1'b1;
      in_s.mem_addr  = 32'h14;
      next_cycle();
      rst = 1'b0;
      next_cycle();
      check("rst mid-busy ready", 32'(out_s.mem_ready), 32'd0);
      check("rst mid-busy error", 32'(out_s.mem_error), 32'd0);
      check("rst mid-busy rdata", out_s.mem_rdata, 32'h0);
      rst = 1'b1;
      in_s.mem_valid = 1'b0;
      quiet("after reset", 3);
      do_req(32'h14, 32'h0, 4'h0, lat, rsp);
      check("post-reset latency", 32'(lat), 32'd2);
      check("post-reset rdata", rsp.mem_rdata, 32'h0000_0013);
      check("post-reset error", 32'(rsp.mem_error), 32'd0);
      in_s.mem_valid = 1'b0;
      quiet("final idle", 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
